// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter.
//   state_t         transmitter FSM states
//   DEF_*           default timing constants at 50 MHz
//   CNT_W           width of the saturating timer
//   FRAME_LEN       data bits + parity + stop shifted out per command byte
//   make_frame()    builds {stop, odd parity, data}
//   sat_inc()       saturating timer increment
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK_WAIT,
    RELEASE,
    DONE,
    ERR
  } state_t;

  localparam int DEF_CLK_HZ         = 50000000;
  localparam int DEF_INHIBIT_CYCLES = 6000;    // 120 us
  localparam int DEF_START_TIMEOUT  = 750000;  // 15 ms
  localparam int DEF_XFER_TIMEOUT   = 100000;  // 2 ms
  localparam int DEF_FILTER_LEN     = 8;

  localparam int CNT_W = 20;

  localparam logic [3:0] FRAME_LEN = 4'd10;

  // Bit 0 goes out first; parity makes the count of ones in data+parity odd.
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == {CNT_W{1'b1}}) ? value : value + CNT_W'(1);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 line.
//   clk    system clock
//   rst_n  asynchronous active-low reset (level presets to 1, the idle line)
//   pin    raw pin level, asynchronous to clk
//   level  filtered level: changes only after FILTER_LEN equal samples
//   fall   one-cycle strobe in the cycle level goes 1 -> 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          level_reg;
  logic          fall_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= 2'b11;
      cnt_reg   <= '0;
      level_reg <= 1'b1;
      fall_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pin};
      fall_reg <= 1'b0;
      // Any sample agreeing with the accepted level restarts the run, so
      // only an unbroken run of FILTER_LEN differing samples flips it.
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
        fall_reg  <= level_reg;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign level = level_reg;
  assign fall  = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
//   CLOCK_50    system clock
//   RESET_N     asynchronous active-low reset
//   tx_data     byte to send, captured when tx_start is accepted in IDLE
//   tx_start    one-cycle request; ignored while tx_busy=1
//   tx_busy     high from the cycle after acceptance through DONE/ERR
//   tx_done     one-cycle pulse: frame sent and ACK seen, lines idle again
//   tx_error    one-cycle pulse: timeout or missing ACK
//   ps2_clk_in  raw PS2_CLK level
//   ps2_dat_in  raw PS2_DAT level
//   ps2_clk_oe  1 pulls PS2_CLK low
//   ps2_dat_oe  1 pulls PS2_DAT low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
  parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe
);

  localparam logic [CNT_W-1:0] INH_LAST    = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LIMIT = CNT_W'(START_TIMEOUT);
  localparam logic [CNT_W-1:0] XFER_LIMIT  = CNT_W'(XFER_TIMEOUT);

  // CLK_HZ only documents the clock the timing constants were derived for.
  if (CLK_HZ <= 0) begin : g_clk_hz_invalid
  end

  logic clk_level;
  logic clk_fall;
  logic dat_level;
  logic dat_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .pin   (ps2_clk_in),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk   (CLOCK_50),
    .rst_n (RESET_N),
    .pin   (ps2_dat_in),
    .level (dat_level),
    .fall  (dat_fall_unused)
  );

  state_t           state_reg,  state_next;
  logic [9:0]       frame_reg,  frame_next;
  logic [3:0]       bitcnt_reg, bitcnt_next;
  logic [CNT_W-1:0] timer_reg,  timer_next;
  logic             bit_reg,    bit_next;    // frame bit currently on DAT
  logic             ack_reg,    ack_next;    // DAT level captured at the ACK fall

  // State register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg  <= IDLE;
      frame_reg  <= '0;
      bitcnt_reg <= '0;
      timer_reg  <= '0;
      bit_reg    <= 1'b0;
      ack_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      frame_reg  <= frame_next;
      bitcnt_reg <= bitcnt_next;
      timer_reg  <= timer_next;
      bit_reg    <= bit_next;
      ack_reg    <= ack_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    frame_next  = frame_reg;
    bitcnt_next = bitcnt_reg;
    timer_next  = timer_reg;
    bit_next    = bit_reg;
    ack_next    = ack_reg;

    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          frame_next  = make_frame(tx_data);
          bitcnt_next = '0;
          timer_next  = '0;
          state_next  = INHIBIT;
        end
      end

      INHIBIT: begin
        if (timer_reg >= INH_LAST) begin
          timer_next = '0;
          state_next = REQ;
        end else begin
          timer_next = sat_inc(timer_reg);
        end
      end

      REQ: begin
        if (clk_fall) begin
          bit_next    = frame_reg[0];
          frame_next  = {1'b1, frame_reg[9:1]};
          bitcnt_next = 4'd1;
          timer_next  = '0;
          state_next  = BITS;
        end else if (timer_reg >= START_LIMIT) begin
          state_next = ERR;
        end else begin
          timer_next = sat_inc(timer_reg);
        end
      end

      BITS: begin
        if (timer_reg >= XFER_LIMIT) begin
          state_next = ERR;
        end else begin
          timer_next = sat_inc(timer_reg);
          if (clk_fall) begin
            if (bitcnt_reg == FRAME_LEN) begin
              // The device holds DAT low across this fall to acknowledge;
              // capture the level now and judge it in ACK_WAIT.
              ack_next   = dat_level;
              state_next = ACK_WAIT;
            end else begin
              bit_next    = frame_reg[0];
              frame_next  = {1'b1, frame_reg[9:1]};
              bitcnt_next = bitcnt_reg + 4'd1;
            end
          end
        end
      end

      ACK_WAIT: begin
        if (timer_reg >= XFER_LIMIT) begin
          state_next = ERR;
        end else begin
          timer_next = sat_inc(timer_reg);
          state_next = ack_reg ? ERR : RELEASE;
        end
      end

      RELEASE: begin
        if (timer_reg >= XFER_LIMIT) begin
          state_next = ERR;
        end else begin
          timer_next = sat_inc(timer_reg);
          if (clk_level && dat_level) begin
            state_next = DONE;
          end
        end
      end

      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    tx_busy    = 1'b0;
    tx_done    = 1'b0;
    tx_error   = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;

    case (state_reg)
      INHIBIT: begin
        tx_busy    = 1'b1;
        ps2_clk_oe = 1'b1;
        // Start bit goes low in the last inhibit cycle, while CLK is still held.
        ps2_dat_oe = (timer_reg >= INH_LAST);
      end
      REQ: begin
        tx_busy    = 1'b1;
        ps2_dat_oe = 1'b1;
      end
      BITS: begin
        tx_busy    = 1'b1;
        ps2_dat_oe = ~bit_reg;
      end
      ACK_WAIT: tx_busy = 1'b1;
      RELEASE:  tx_busy = 1'b1;
      DONE: begin
        tx_busy = 1'b1;
        tx_done = 1'b1;
      end
      ERR: begin
        tx_busy  = 1'b1;
        tx_error = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a PS/2 device model
// on an open-drain bus. Timing constants are scaled down to keep runs short.
module tb_ps2_host_tx;

  localparam int INH      = 60;
  localparam int START_TO = 3000;
  localparam int XFER_TO  = 2000;
  localparam int FILT     = 8;
  localparam int H        = 40;   // device clock half-period in system cycles

  localparam int M_ACK   = 0;
  localparam int M_NOACK = 1;
  localparam int M_NOCLK = 2;
  localparam int M_ABORT = 3;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       ps2_clk_in, ps2_dat_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always #10 CLOCK_50 = ~CLOCK_50;

  ps2_host_tx #(
    .CLK_HZ         (50000000),
    .INHIBIT_CYCLES (INH),
    .START_TIMEOUT  (START_TO),
    .XFER_TIMEOUT   (XFER_TO),
    .FILTER_LEN     (FILT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int done_cnt = 0, err_cnt = 0;
  int run = 0, ovl = 0, inh_len = 0, inh_ovl = 0, req_cyc = 0, err_cyc = 0;
  logic [9:0] last_frame = '0;

  logic bit_q[$];      // expected bits as the device should sample them
  int   outcome_q[$];  // 0 = tx_done expected, 1 = tx_error expected

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Pulse monitor and inhibit-phase measurement.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (ps2_clk_oe) begin
      run++;
      if (ps2_dat_oe) ovl++;
    end else if (run > 0) begin
      inh_len = run;
      inh_ovl = ovl;
      req_cyc = cyc;
      run = 0;
      ovl = 0;
    end
    if (tx_done) begin
      done_cnt++;
      if (outcome_q.size() == 0) check("unexpected_done", 1, 0);
      else check("outcome_at_done", 0, outcome_q.pop_front());
    end
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
      if (outcome_q.size() == 0) check("unexpected_error", 1, 0);
      else check("outcome_at_error", 1, outcome_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] b, input int outcome);
    @(negedge CLOCK_50);
    tx_data  = b;
    tx_start = 1'b1;
    @(negedge CLOCK_50);
    tx_start = 1'b0;
    for (int k = 0; k < 8; k++) bit_q.push_back(b[k]);
    bit_q.push_back(~^b);
    bit_q.push_back(1'b1);
    if (outcome >= 0) outcome_q.push_back(outcome);
    $display("send byte=%02h expect=%0d", b, outcome);
  endtask

  task automatic device(input int mode);
    int n;
    logic s;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 20000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (n >= 20000) begin
      check("req_seen", 0, 1);
      return;
    end
    repeat (3 * H) @(negedge CLOCK_50);
    check("start_bit_low", ps2_dat_in, 0);
    if (mode == M_NOCLK) return;
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge CLOCK_50);
      if (mode == M_ABORT && i == 4) return;
      dev_clk_low = 1'b0;
      if (i <= 10) begin
        s = ps2_dat_in;
        last_frame[i-1] = s;
        if (bit_q.size() == 0) check("bit_queue_empty", 0, 1);
        else check($sformatf("frame_bit%0d", i - 1), s, bit_q.pop_front());
      end
      repeat (H / 2) @(negedge CLOCK_50);
      if (i == 10 && mode == M_ACK) dev_dat_low = 1'b1;
      repeat (H / 2) @(negedge CLOCK_50);
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (tx_busy && n < limit) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("idle_in_time", (n < limit), 1);
  endtask

  initial begin
    int d0, e0, d;
    #5;
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_dat_oe", ps2_dat_oe, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    check("rst_error", tx_error, 0);
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (20) @(negedge CLOCK_50);

    // 0xED with ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hED, 0);
    device(M_ACK);
    wait_idle(XFER_TO);
    check("ed_inhibit_len", inh_len, INH);
    check("ed_start_overlap", inh_ovl, 1);
    check("ed_frame", {22'd0, last_frame}, 32'h3ED);
    check("ed_done", done_cnt - d0, 1);
    check("ed_error", err_cnt - e0, 0);
    check("ed_queue_drained", bit_q.size(), 0);

    // 0x01 then 0xFF: parity 0 then 1
    d0 = done_cnt;
    send(8'h01, 0);
    device(M_ACK);
    wait_idle(XFER_TO);
    check("p01_parity", last_frame[8], 0);
    send(8'hFF, 0);
    device(M_ACK);
    wait_idle(XFER_TO);
    check("pff_parity", last_frame[8], 1);
    check("p01_ff_done", done_cnt - d0, 2);

    // Device never clocks
    d0 = done_cnt; e0 = err_cnt;
    send(8'h3C, 1);
    device(M_NOCLK);
    wait_idle(START_TO + 1000);
    d = err_cyc - req_cyc;
    check("noclk_error", err_cnt - e0, 1);
    check("noclk_no_done", done_cnt - d0, 0);
    check("noclk_window", (d >= START_TO && d <= START_TO + FILT + 4), 1);
    check("noclk_clk_oe", ps2_clk_oe, 0);
    check("noclk_dat_oe", ps2_dat_oe, 0);
    bit_q.delete();

    // Device omits ACK
    d0 = done_cnt; e0 = err_cnt;
    send(8'hA5, 1);
    device(M_NOACK);
    wait_idle(XFER_TO);
    check("noack_error", err_cnt - e0, 1);
    check("noack_no_done", done_cnt - d0, 0);
    check("noack_dat_oe", ps2_dat_oe, 0);

    // Reset in the middle of the bit phase
    d0 = done_cnt; e0 = err_cnt;
    send(8'h00, -1);
    device(M_ABORT);
    check("pre_rst_busy", tx_busy, 1);
    check("pre_rst_dat_oe", ps2_dat_oe, 1);
    #3;
    RESET_N = 1'b0;
    #1;
    check("midrst_clk_oe", ps2_clk_oe, 0);
    check("midrst_dat_oe", ps2_dat_oe, 0);
    check("midrst_busy", tx_busy, 0);
    dev_clk_low = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    bit_q.delete();
    repeat (20) @(negedge CLOCK_50);
    check("midrst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
    send(8'h55, 0);
    device(M_ACK);
    wait_idle(XFER_TO);
    check("after_rst_done", done_cnt - d0, 1);
    check("after_rst_frame", {22'd0, last_frame}, 32'h355);

    // Second tx_start during INHIBIT is ignored
    d0 = done_cnt;
    send(8'hED, 0);
    begin
      int n;
      n = 0;
      while (!ps2_clk_oe && n < 100) begin
        @(negedge CLOCK_50);
        n++;
      end
      check("inhibit_seen", ps2_clk_oe, 1);
    end
    repeat (10) @(negedge CLOCK_50);
    tx_data  = 8'hAA;
    tx_start = 1'b1;
    @(negedge CLOCK_50);
    tx_start = 1'b0;
    device(M_ACK);
    wait_idle(XFER_TO);
    check("overlap_frame", {22'd0, last_frame}, 32'h3ED);
    repeat (200) @(negedge CLOCK_50);
    check("overlap_one_done", done_cnt - d0, 1);
    check("overlap_idle", tx_busy, 0);

    // tx_start in the tx_done cycle is ignored
    send(8'h12, 0);
    device(M_ACK);
    begin
      int n;
      n = 0;
      while (!tx_done && n < XFER_TO) begin
        @(negedge CLOCK_50);
        n++;
      end
      check("done_seen", tx_done, 1);
    end
    tx_data  = 8'h34;
    tx_start = 1'b1;
    @(negedge CLOCK_50);
    tx_start = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check("start_at_done_ignored", tx_busy, 0);
    check("outcomes_drained", outcome_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(60000 * 20);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter, the send direction beside the existing ps2_keyboard receiver on the same PS2_CLK/PS2_DAT pair. It sends command bytes to the keyboard, for example 0xED set-LEDs with its argument, or 0xFF reset. It handles the full handshake: clock inhibit, request-to-send, device-clocked bit shifting, odd parity, stop bit, line-ACK check and timeouts. The top level drives the open-drain pins from the *_oe outputs and holds the receiver off while tx_busy=1.

Parameters:
CLK_HZ, 50000000, CLOCK_50 frequency (documentation only)
INHIBIT_CYCLES, 6000, CLK low hold before request (120 us)
START_TIMEOUT, 750000, limit for the first device clock fall after request (15 ms)
XFER_TIMEOUT, 100000, limit from the first device fall to ACK (2 ms)
FILTER_LEN, 8, consecutive equal samples needed to accept a line level

Ports:
CLOCK_50  in  1  system clock; single clock domain
RESET_N  in  1  asynchronous active-low reset
tx_data  in  8  byte to send, sampled when tx_start is accepted
tx_start  in  1  one-cycle request pulse; ignored while tx_busy=1
tx_busy  out  1  high from acceptance until DONE/ERR exit
tx_done  out  1  one-cycle pulse: byte sent and ACK seen
tx_error  out  1  one-cycle pulse: timeout or missing ACK
ps2_clk_in  in  1  raw PS2_CLK pin level
ps2_dat_in  in  1  raw PS2_DAT pin level
ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer): state=IDLE, all outputs 0, so both lines are released in the reset cycle; counters 0; filters preset to 1.
- Input conditioning: each line passes a 2-flop synchronizer, then a FILTER_LEN stable-sample filter. clk_fall is a one-cycle strobe when the filtered CLK goes 1->0. Latency from pin to strobe is 2+FILTER_LEN cycles.
- Shift register frame[9:0] = {1'b1 stop, ~^tx_data odd parity, tx_data[7:0]}, loaded at acceptance. bitcnt is 4 bits.
- IDLE: clk_oe=0, dat_oe=0. On tx_start: load frame, tx_busy=1, go to INHIBIT next cycle.
- INHIBIT: clk_oe=1, counter runs INHIBIT_CYCLES.
  - In the final inhibit cycle, set dat_oe=1 (start bit; data low while clock still low).
  - Next cycle: clk_oe=0 and go to REQ.
- REQ: dat_oe=1, timer running.
  - On clk_fall: drive frame[0] (dat_oe = ~frame[0]), shift, bitcnt=1, restart timer, go to BITS.
  - If the timer reaches START_TIMEOUT: go to ERR.
- BITS: on each clk_fall, drive the next frame bit and increment bitcnt.
  - The stop bit is driven when bitcnt goes 9->10, and it always releases (dat_oe=0).
  - The next clk_fall after the stop bit goes to ACK_WAIT.
- ACK_WAIT: on clk_fall, sample filtered DAT. 0 = ACK: go to RELEASE. 1 = no ACK: go to ERR.
- XFER_TIMEOUT is checked in BITS and ACK_WAIT against the timer started at the first fall. Expiry goes to ERR.
- RELEASE: both oe=0. Wait for filtered CLK=1 and DAT=1 together, then go to DONE. This state is also covered by XFER_TIMEOUT.
- DONE: tx_done=1 for one cycle, tx_busy=0 from the next cycle, go to IDLE.
- ERR: release both lines, tx_error=1 for one cycle, go to IDLE. There is no automatic retry.
- tx_start asserted in the same cycle tx_done or tx_error pulses is ignored (tx_busy is still 1 in that cycle).
- Counters are 20 bits and saturate, with no wrap.

Decomposition:
- Package ps2_pkg holds:
  - state enum {IDLE, INHIBIT, REQ, BITS, ACK_WAIT, RELEASE, DONE, ERR}
  - default timing constants
  - frame-length constant 4'd10
- Sub-module ps2_line_filter (synchronizer + stable filter + fall strobe), instantiated once per line; its filtered output resets to 1.

Test Plan:
- Send 0xED to a device model clocking at 2000-cycle half-period that ACKs. Required response:
  - CLK held low 6000 cycles, then DAT low.
  - Bits sampled on rising edges: 1,0,1,1,0,1,1,1, parity 1, stop 1, ACK 0.
  - One tx_done pulse and no tx_error.
- Send 0x01 then 0xFF. Parity bits must be 0 and 1; both transfers end in tx_done.
- Device model never clocks after the request: tx_error pulses 750000 cycles after REQ entry (plus filter latency), and both oe are 0 afterwards.
- Device model omits the ACK (DAT high on the 11th fall): tx_error pulses, no tx_done.
- Assert RESET_N low during BITS at bit 4: clk_oe and dat_oe are 0 in the same cycle, tx_busy=0, and a later 0x55 transfer completes normally.
- tx_start pulsed with 0xAA during INHIBIT of an 0xED transfer: the frame sent is still 0xED, and exactly one tx_done occurs.
